// File: rtl/channelizer2.sv
// Two-word sop/eop packet stream to parallel ch1/ch2 pair; pair valid one cycle after eop transfer.
// Output held under backpressure; second-word acceptance stalls, a ch1 word is still taken while idle.
module channelizer2 #(
  parameter int DATA_WIDTH    = 24,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  input  logic                     in_sop,
  input  logic                     in_eop,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    out_data_1,
  output logic [DATA_WIDTH-1:0]    out_data_2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam logic [1:0] S_FIRST  = 2'd0;
  localparam logic [1:0] S_SECOND = 2'd1;
  localparam logic [1:0] S_DROP   = 2'd2;

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic [DATA_WIDTH-1:0] hold;
  logic                  xfer;
  logic                  load_hold;
  logic                  load_out;
  logic                  err_now;

  // Only the second word writes the output register, so only it must wait for space.
  assign in_ready = reset_n && ((state != S_SECOND) || !out_valid || out_ready);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    next_state = state;
    load_hold  = 1'b0;
    load_out   = 1'b0;
    err_now    = 1'b0;
    if (xfer) begin
      case (state)
        S_FIRST: begin
          if (in_sop && !in_eop) begin
            load_hold  = 1'b1;
            next_state = S_SECOND;
          end else begin
            err_now = 1'b1;
          end
        end
        S_SECOND: begin
          if (in_eop && !in_sop) begin
            load_out   = 1'b1;
            next_state = S_FIRST;
          end else if (in_sop) begin
            // Restart: a sop+eop word here is dropped, a plain sop becomes the new ch1.
            err_now = 1'b1;
            if (in_eop) begin
              next_state = S_FIRST;
            end else begin
              load_hold  = 1'b1;
              next_state = S_SECOND;
            end
          end else begin
            err_now    = 1'b1;
            next_state = S_DROP;
          end
        end
        S_DROP: begin
          if (in_eop && !in_sop) begin
            next_state = S_FIRST;
          end else if (in_sop && !in_eop) begin
            load_hold  = 1'b1;
            next_state = S_SECOND;
          end
        end
        default: next_state = S_FIRST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_FIRST;
      hold  <= '0;
    end else begin
      state <= next_state;
      if (load_hold) begin
        hold <= in_data;
      end
    end
  end

  // A load in the same cycle as acceptance replaces the old pair without a bubble.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data_1 <= '0;
      out_data_2 <= '0;
    end else if (load_out) begin
      out_valid  <= 1'b1;
      out_data_1 <= hold;
      out_data_2 <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      frame_err <= err_now;
      if (err_now && (err_count != {ERR_CNT_WIDTH{1'b1}})) begin
        err_count <= err_count + ERR_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_channelizer2.sv
// Directed per-cycle vector table for channelizer2, plus a pair scoreboard and a saturation run.
module tb_channelizer2;

  localparam int DW = 24;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, in_valid, in_sop, in_eop, in_ready;
  logic          out_valid, out_ready, frame_err;
  logic [DW-1:0] in_data, out_data_1, out_data_2;
  logic [CW-1:0] err_count;

  logic          s_reset_n, s_in_valid, s_in_ready, s_out_valid, s_frame_err;
  logic [DW-1:0] s_in_data, s_out_data_1, s_out_data_2;
  logic [3:0]    s_err_count;

  channelizer2 #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
    .out_data_1(out_data_1), .out_data_2(out_data_2), .out_valid(out_valid),
    .out_ready(out_ready), .frame_err(frame_err), .err_count(err_count)
  );

  channelizer2 #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset_n(s_reset_n), .in_data(s_in_data), .in_valid(s_in_valid),
    .in_sop(1'b0), .in_eop(1'b0), .in_ready(s_in_ready),
    .out_data_1(s_out_data_1), .out_data_2(s_out_data_2), .out_valid(s_out_valid),
    .out_ready(1'b1), .frame_err(s_frame_err), .err_count(s_err_count)
  );

  typedef struct {
    logic          rst_n;
    logic          vld;
    logic          sop;
    logic          eop;
    logic [DW-1:0] dat;
    logic          ordy;
    logic          exp_irdy;
    logic          exp_ovld;
    logic [DW-1:0] exp_d1;
    logic [DW-1:0] exp_d2;
    logic          exp_ferr;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } pair_t;

  vec_t  vecs[$];
  pair_t got[$];
  pair_t want[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(input int r, input int v, input int s, input int e, input int d,
                              input int ordy, input int irdy, input int ov, input int d1,
                              input int d2, input int fe, input int c);
    vec_t m;
    m.rst_n    = (r != 0);
    m.vld      = (v != 0);
    m.sop      = (s != 0);
    m.eop      = (e != 0);
    m.dat      = DW'(d);
    m.ordy     = (ordy != 0);
    m.exp_irdy = (irdy != 0);
    m.exp_ovld = (ov != 0);
    m.exp_d1   = DW'(d1);
    m.exp_d2   = DW'(d2);
    m.exp_ferr = (fe != 0);
    m.exp_cnt  = CW'(c);
    return m;
  endfunction

  function automatic pair_t pr(input int a, input int b);
    pair_t p;
    p.a = DW'(a);
    p.b = DW'(b);
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Accepted pairs, sampled mid-cycle when the handshake inputs are stable.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      got.push_back(pr(int'(out_data_1), int'(out_data_2)));
    end
  end

  initial begin
    int pulses;
    int exp_c;

    reset_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_data = '0; out_ready = 1'b1;
    s_reset_n = 1'b0; s_in_valid = 1'b0; s_in_data = '0;

    //                 r v s e data        ordy irdy ov d1         d2         fe cnt
    vecs.push_back(mk(0,0,0,0,0,           1,   0,   0, 0,         0,         0, 0));
    // normal back-to-back pairs
    vecs.push_back(mk(1,1,1,0,'h000001,    1,   1,   0, 0,         0,         0, 0));
    vecs.push_back(mk(1,1,0,1,'h000002,    1,   1,   1, 'h000001,  'h000002,  0, 0));
    vecs.push_back(mk(1,1,1,0,'hFFFFFF,    1,   1,   0, 'h000001,  'h000002,  0, 0));
    vecs.push_back(mk(1,1,0,1,'h800000,    1,   1,   1, 'hFFFFFF,  'h800000,  0, 0));
    vecs.push_back(mk(1,0,0,0,0,           1,   1,   0, 'hFFFFFF,  'h800000,  0, 0));
    // backpressure: A loads, out_ready low for 5 cycles while B waits
    vecs.push_back(mk(1,1,1,0,'h0000A1,    0,   1,   0, 'hFFFFFF,  'h800000,  0, 0));
    vecs.push_back(mk(1,1,0,1,'h0000A2,    0,   1,   1, 'h0000A1,  'h0000A2,  0, 0));
    vecs.push_back(mk(1,1,1,0,'h0000B1,    0,   1,   1, 'h0000A1,  'h0000A2,  0, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1,1,0,1,'h0000B2,  0,   0,   1, 'h0000A1,  'h0000A2,  0, 0));
    vecs.push_back(mk(1,1,0,1,'h0000B2,    1,   1,   1, 'h0000B1,  'h0000B2,  0, 0));
    vecs.push_back(mk(1,0,0,0,0,           1,   1,   0, 'h0000B1,  'h0000B2,  0, 0));
    // missing sop
    vecs.push_back(mk(1,1,0,0,'h123456,    1,   1,   0, 'h0000B1,  'h0000B2,  1, 1));
    vecs.push_back(mk(1,1,1,0,'h111111,    1,   1,   0, 'h0000B1,  'h0000B2,  0, 1));
    vecs.push_back(mk(1,1,0,1,'h222222,    1,   1,   1, 'h111111,  'h222222,  0, 1));
    vecs.push_back(mk(1,0,0,0,0,           1,   1,   0, 'h111111,  'h222222,  0, 1));
    // reset, then restart and long packet
    vecs.push_back(mk(0,0,0,0,0,           1,   0,   0, 0,         0,         0, 0));
    vecs.push_back(mk(1,1,1,0,'hAAAAAA,    1,   1,   0, 0,         0,         0, 0));
    vecs.push_back(mk(1,1,1,0,'hBBBBBB,    1,   1,   0, 0,         0,         1, 1));
    vecs.push_back(mk(1,1,0,1,'hCCCCCC,    1,   1,   1, 'hBBBBBB,  'hCCCCCC,  0, 1));
    vecs.push_back(mk(1,1,1,0,'h010101,    1,   1,   0, 'hBBBBBB,  'hCCCCCC,  0, 1));
    vecs.push_back(mk(1,1,0,0,'h020202,    1,   1,   0, 'hBBBBBB,  'hCCCCCC,  1, 2));
    vecs.push_back(mk(1,1,0,0,'h030303,    1,   1,   0, 'hBBBBBB,  'hCCCCCC,  0, 2));
    vecs.push_back(mk(1,1,0,1,'h040404,    1,   1,   0, 'hBBBBBB,  'hCCCCCC,  0, 2));
    vecs.push_back(mk(1,1,0,0,'h050505,    1,   1,   0, 'hBBBBBB,  'hCCCCCC,  1, 3));
    // reset mid-packet
    vecs.push_back(mk(1,1,1,0,'h0F0F0F,    1,   1,   0, 'hBBBBBB,  'hCCCCCC,  0, 3));
    vecs.push_back(mk(0,0,0,0,0,           1,   0,   0, 0,         0,         0, 0));
    vecs.push_back(mk(1,1,0,1,'h111111,    1,   1,   0, 0,         0,         1, 1));
    vecs.push_back(mk(1,0,0,0,0,           1,   1,   0, 0,         0,         0, 1));
    // one-word packet, restart with sop+eop, then back-to-back errors
    vecs.push_back(mk(1,1,1,1,'h090909,    1,   1,   0, 0,         0,         1, 2));
    vecs.push_back(mk(1,0,0,0,0,           1,   1,   0, 0,         0,         0, 2));
    vecs.push_back(mk(1,1,1,0,'h0A0A0A,    1,   1,   0, 0,         0,         0, 2));
    vecs.push_back(mk(1,1,1,1,'h0B0B0B,    1,   1,   0, 0,         0,         1, 3));
    vecs.push_back(mk(1,1,0,1,'h0C0C0C,    1,   1,   0, 0,         0,         1, 4));
    vecs.push_back(mk(1,0,0,0,0,           1,   1,   0, 0,         0,         0, 4));

    want.push_back(pr('h000001, 'h000002));
    want.push_back(pr('hFFFFFF, 'h800000));
    want.push_back(pr('h0000A1, 'h0000A2));
    want.push_back(pr('h0000B1, 'h0000B2));
    want.push_back(pr('h111111, 'h222222));
    want.push_back(pr('hBBBBBB, 'hCCCCCC));

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      reset_n   = vecs[i].rst_n;
      in_valid  = vecs[i].vld;
      in_sop    = vecs[i].sop;
      in_eop    = vecs[i].eop;
      in_data   = vecs[i].dat;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_irdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ovld));
      check($sformatf("v%0d out_data_1", i), 32'(out_data_1), 32'(vecs[i].exp_d1));
      check($sformatf("v%0d out_data_2", i), 32'(out_data_2), 32'(vecs[i].exp_d2));
      check($sformatf("v%0d frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
      check($sformatf("v%0d err_count", i), 32'(err_count), 32'(vecs[i].exp_cnt));
    end
    in_valid = 1'b0;

    check("pairs delivered", 32'(got.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < got.size(); i++) begin
      check($sformatf("pair%0d ch1", i), 32'(got[i].a), 32'(want[i].a));
      check($sformatf("pair%0d ch2", i), 32'(got[i].b), 32'(want[i].b));
    end

    // Saturation on a 4-bit counter: 20 flagless words in S_FIRST.
    @(posedge clk);
    #1;
    s_reset_n = 1'b1;
    check("sat reset count", 32'(s_err_count), 32'd0);
    pulses = 0;
    s_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_in_data = DW'(i);
      @(posedge clk);
      #1;
      if (s_frame_err === 1'b1) pulses++;
      exp_c = (i + 1 > 15) ? 15 : i + 1;
      check($sformatf("sat%0d err_count", i), 32'(s_err_count), 32'(exp_c));
      check($sformatf("sat%0d frame_err", i), 32'(s_frame_err), 32'd1);
    end
    s_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("sat final frame_err", 32'(s_frame_err), 32'd0);
    check("sat final err_count", 32'(s_err_count), 32'd15);
    check("sat pulse total", 32'(pulses), 32'd20);
    check("sat no output", 32'(s_out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
